sub_bytes_serial: RTL and testbench

SUB_BYTES_SERIAL -- requirements
Module: sub_bytes_serial

---
 rtl/sub_bytes_serial.sv | 107 ++++++++++
 tb/tb_sub_bytes_serial.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: byte-serial AES SubBytes/InvSubBytes, one byte per clock through a single shared S-box.
// bSbox: bidirectional AES S-box built from GF(2^8) inversion (x^254) wrapped by the affine maps.
module bSbox (
  input  logic [7:0] a,
  input  logic       encrypt,
  output logic [7:0] q
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      p = y[i] ? p ^ t : p;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  logic [7:0] pre, x2, x3, x12, x15, x240, inv;

  // x^254 via 2,3,12,15,240 chain; zero maps to zero naturally
  always_comb begin
    pre  = encrypt ? a : rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
    x2   = gmul(pre, pre);
    x3   = gmul(x2, pre);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15))),
                gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15))));
    inv  = gmul(gmul(x240, x12), x2);
    q    = encrypt ? inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63 : inv;
  end
endmodule

module sub_bytes_serial (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         enc,
  input  logic [127:0] state_in,
  output logic [127:0] state_out,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_q, out_d;
  logic         mode_q, mode_d;
  logic         done_q, done_d;
  logic [7:0]   sbox_out;
  logic         accept, last;

  bSbox u_sbox (
    .a       (work_q[127:120]),
    .encrypt (mode_q),
    .q       (sbox_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      mode_q  <= 1'b1;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    accept  = (state_q == IDLE) && start;
    last    = (state_q == RUN) && (cnt_q == 4'd15);
    state_d = accept ? RUN : last ? IDLE : state_q;
  end

  // the byte leaving the top of work re-enters at the bottom substituted
  always_comb begin
    work_d = accept ? state_in : (state_q == RUN) ? {work_q[119:0], sbox_out} : work_q;
    mode_d = accept ? enc : mode_q;
    cnt_d  = accept ? 4'd0 : (state_q == RUN) ? cnt_q + 4'd1 : cnt_q;
    out_d  = last ? {work_q[119:0], sbox_out} : out_q;
    done_d = last;
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = done_q;
    state_out = out_q;
  end
endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb_sub_bytes_serial: vector table plus randomized blocks against a table-based S-box model.
module tb_sub_bytes_serial;
  logic         clk = 0, rst = 0, start = 0, enc = 1;
  logic [127:0] state_in = '0;
  logic [127:0] state_out;
  logic         busy, done;
  int           tests = 0, fails = 0;
  logic [7:0]   fwd [256];
  logic [7:0]   inv_t [256];

  typedef struct {
    logic [127:0] din;
    logic         e;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[$];

  sub_bytes_serial dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .enc       (enc),
    .state_in  (state_in),
    .state_out (state_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p ^= t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] c, v, s, y;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 0;
      for (int k = 1; k < 256; k++) begin
        y = 8'(k);
        if (gm(8'(x), y) == 8'h01) v = y;
      end
      for (int i = 0; i < 8; i++)
        s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
      fwd[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic e);
    logic [127:0] r;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = s[127 - 8 * i -: 8];
      r[127 - 8 * i -: 8] = e ? fwd[b] : inv_t[b];
    end
    return r;
  endfunction

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic run_block(input logic [127:0] s, input logic e, output logic [127:0] res,
                           output int lat, output int bz);
    @(negedge clk);
    state_in = s;
    enc = e;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = -1;
    bz = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bz++;
    end
    res = state_out;
    @(posedge clk);
    #1 chk("done_one_cycle", 128'(done), 128'd0);
  endtask

  logic [127:0] res, a_blk, b_blk, got1, got2;
  int lat, bz, nd, first, d1, d2;
  logic e_r;

  initial begin
    build_tables();
    #2;
    chk("reset_out", state_out, '0);
    chk("reset_busy", 128'(busy), 0);
    chk("reset_done", 128'(done), 0);
    @(negedge clk) rst = 1;

    vecs.push_back('{128'h00112233445566778899aabbccddeeff, 1'b1, 128'h638293c31bfc33f5c4eeacea4bc12816});
    vecs.push_back('{128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0, 128'h00112233445566778899aabbccddeeff});
    vecs.push_back('{128'h0, 1'b1, {16{8'h63}}});
    vecs.push_back('{{16{8'h53}}, 1'b1, {16{8'hed}}});
    vecs.push_back('{{16{8'h63}}, 1'b0, 128'h0});
    for (int i = 0; i < 6; i++) begin
      a_blk = {$urandom, $urandom, $urandom, $urandom};
      e_r = 1'($urandom_range(0, 1));
      vecs.push_back('{a_blk, e_r, model(a_blk, e_r)});
    end
    foreach (vecs[i]) begin
      run_block(vecs[i].din, vecs[i].e, res, lat, bz);
      chk($sformatf("vec%0d_out", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd16);
      chk($sformatf("vec%0d_busy_cycles", i), 128'(bz), 128'd16);
    end

    // inputs changed and start pulsed mid-block must be ignored
    a_blk = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    state_in = a_blk; enc = 1; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #1 start = 1; enc = 0; state_in = ~a_blk;
    repeat (5) @(posedge clk);
    #1 start = 0;
    nd = 0; first = -1; got1 = '0;
    for (int k = 10; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        if (first < 0) begin first = k; got1 = state_out; end
      end
    end
    chk("ignore_out", got1, model(a_blk, 1'b1));
    chk("ignore_latency", 128'(first), 128'd16);
    chk("ignore_done_count", 128'(nd), 128'd1);

    // asynchronous reset mid-block
    @(negedge clk);
    state_in = {$urandom, $urandom, $urandom, $urandom}; enc = 1; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (7) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("abort_out", state_out, '0);
    chk("abort_busy", 128'(busy), 0);
    chk("abort_done", 128'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("abort_no_done", 128'(nd), 0);
    chk("abort_out_held", state_out, '0);
    a_blk = {$urandom, $urandom, $urandom, $urandom};
    run_block(a_blk, 1'b0, res, lat, bz);
    chk("after_reset_out", res, model(a_blk, 1'b0));
    chk("after_reset_latency", 128'(lat), 128'd16);

    // back-to-back with start held across done
    a_blk = {$urandom, $urandom, $urandom, $urandom};
    b_blk = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    state_in = a_blk; enc = 1; start = 1;
    @(posedge clk);
    #1 state_in = b_blk; enc = 0;
    d1 = -1; d2 = -1; got1 = '0; got2 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (d1 < 0) begin d1 = k; got1 = state_out; end
        else if (d2 < 0) begin d2 = k; got2 = state_out; end
      end
      if (k == 17) begin
        chk("b2b_accept_busy", 128'(busy), 128'd1);
        start = 0;
      end
    end
    chk("b2b_first_at", 128'(d1), 128'd16);
    chk("b2b_first_out", got1, model(a_blk, 1'b1));
    chk("b2b_second_at", 128'(d2), 128'd33);
    chk("b2b_second_out", got2, model(b_blk, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
